bus_sel_arb: RTL and testbench

Two-channel nibble arbiter that sits directly upstream of the 4-bit 2:1 bus-select mux. It buffers one word from each of two valid/ready sources, arbitrates between them, and drives the mux's two data buses and its select line from registers. It also presents a single valid/ready handshake for the mux output. The mux result (`bus_sel ? bus_2 : bus_1`) is the transferred word whenever `out_valid` is high.

---
 rtl/bus_sel_arb.sv | 110 +++++++++++
 tb/tb_bus_sel_arb.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_sel_arb.sv
// Two-channel valid/ready nibble arbiter feeding a registered 2:1 bus-select mux.
// Define BUS_SEL_ARB_RR_EN for round-robin arbitration; otherwise channel A has fixed priority.
module bus_sel_arb #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             a_valid,
   output logic             a_ready,
   input  logic [WIDTH-1:0] a_data,
   input  logic             b_valid,
   output logic             b_ready,
   input  logic [WIDTH-1:0] b_data,
   output logic [WIDTH-1:0] bus_1,
   output logic [WIDTH-1:0] bus_2,
   output logic             bus_sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] xfer_cnt
);

   typedef enum logic {IDLE, PRESENT} state_t;

   state_t state, state_nxt;
   logic   a_full, b_full;
   logic   a_cap, b_cap;
   logic   a_clr, b_clr;
   logic   sel_nxt;
   logic   cnt_inc;
   logic   both_pick;
   logic   win;

   assign a_ready   = ~a_full;
   assign b_ready   = ~b_full;
   assign out_valid = (state == PRESENT);
   assign a_cap     = a_valid & ~a_full;
   assign b_cap     = b_valid & ~b_full;

`ifdef BUS_SEL_ARB_RR_EN
   logic last_grant;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         last_grant <= 1'b1;
      else if (cnt_inc)
         last_grant <= bus_sel;
   end

   assign both_pick = ~last_grant;
`else
   assign both_pick = 1'b0;
`endif

   // With only one buffer full that one wins; b_full alone selects B.
   assign win = (a_full & b_full) ? both_pick : b_full;

   always_comb begin
      state_nxt = state;
      sel_nxt   = bus_sel;
      a_clr     = 1'b0;
      b_clr     = 1'b0;
      cnt_inc   = 1'b0;
      case (state)
         IDLE: begin
            if (a_full | b_full) begin
               state_nxt = PRESENT;
               sel_nxt   = win;
            end
         end
         PRESENT: begin
            if (out_ready) begin
               cnt_inc = 1'b1;
               a_clr   = ~bus_sel;
               b_clr   = bus_sel;
               // Hand straight over to the other channel if it is already waiting.
               if (bus_sel ? a_full : b_full)
                  sel_nxt = ~bus_sel;
               else
                  state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         bus_sel  <= 1'b0;
         a_full   <= 1'b0;
         b_full   <= 1'b0;
         bus_1    <= '0;
         bus_2    <= '0;
         xfer_cnt <= '0;
      end else begin
         state   <= state_nxt;
         bus_sel <= sel_nxt;
         a_full  <= (a_full & ~a_clr) | a_cap;
         b_full  <= (b_full & ~b_clr) | b_cap;
         if (a_cap)
            bus_1 <= a_data;
         if (b_cap)
            bus_2 <= b_data;
         if (cnt_inc)
            xfer_cnt <= xfer_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: tb/tb_bus_sel_arb.sv
// Bench for bus_sel_arb: directed scenarios plus random traffic against a buffer/grant model.
module tb_bus_sel_arb;

   localparam int WIDTH = 4;
   localparam int CNT_W = 4;
`ifdef BUS_SEL_ARB_RR_EN
   localparam bit RR_MODE = 1'b1;
`else
   localparam bit RR_MODE = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             a_valid = 1'b0, b_valid = 1'b0, out_ready = 1'b0;
   logic             a_ready, b_ready, bus_sel, out_valid;
   logic [WIDTH-1:0] a_data = '0, b_data = '0, bus_1, bus_2;
   logic [CNT_W-1:0] xfer_cnt;

   int checks = 0;
   int errors = 0;

   // Model: presented channel (-1 none, 0 A, 1 B), buffers, last grant, transfer count.
   int       m_pres;
   bit       m_full [2];
   bit [3:0] m_data [2];
   int       m_sel;
   int       m_last;
   int       m_cnt;

   always #5 clk = ~clk;

   bus_sel_arb #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
      .bus_1(bus_1), .bus_2(bus_2), .bus_sel(bus_sel),
      .out_valid(out_valid), .out_ready(out_ready), .xfer_cnt(xfer_cnt)
   );

   task automatic model_reset();
      m_pres = -1; m_full[0] = 0; m_full[1] = 0;
      m_data[0] = 0; m_data[1] = 0; m_sel = 0; m_last = 1; m_cnt = 0;
   endtask

   task automatic model_edge(input bit av, input bit [3:0] ad, input bit bv,
                             input bit [3:0] bd, input bit orr);
      bit cap_a, cap_b;
      int np;
      cap_a = av && !m_full[0];
      cap_b = bv && !m_full[1];
      np = m_pres;
      if (m_pres >= 0 && orr) begin
         m_cnt++;
         m_last = m_pres;
         m_full[m_pres] = 0;
         np = m_full[1 - m_pres] ? 1 - m_pres : -1;
      end else if (m_pres < 0 && (m_full[0] || m_full[1])) begin
         if (m_full[0] && m_full[1]) np = RR_MODE ? 1 - m_last : 0;
         else np = m_full[0] ? 0 : 1;
      end
      if (np >= 0) m_sel = np;
      m_pres = np;
      if (cap_a) begin m_full[0] = 1; m_data[0] = ad; end
      if (cap_b) begin m_full[1] = 1; m_data[1] = bd; end
   endtask

   task automatic step(input bit av, input bit [3:0] ad, input bit bv,
                       input bit [3:0] bd, input bit orr);
      logic [3:0] mux;
      a_valid = av; a_data = ad; b_valid = bv; b_data = bd; out_ready = orr;
      @(posedge clk);
      model_edge(av, ad, bv, bd, orr);
      #1;
      checks++;
      if (out_valid !== (m_pres >= 0)) begin
         errors++; $display("FAIL out_valid: got %b want %b at %0t", out_valid, m_pres >= 0, $time);
      end
      checks++;
      if (bus_sel !== m_sel[0]) begin
         errors++; $display("FAIL bus_sel: got %b want %0d at %0t", bus_sel, m_sel, $time);
      end
      checks++;
      if (a_ready !== !m_full[0] || b_ready !== !m_full[1]) begin
         errors++; $display("FAIL ready: got a=%b b=%b want a=%b b=%b at %0t",
                            a_ready, b_ready, !m_full[0], !m_full[1], $time);
      end
      checks++;
      if (bus_1 !== m_data[0] || bus_2 !== m_data[1]) begin
         errors++; $display("FAIL buses: got %h/%h want %h/%h at %0t",
                            bus_1, bus_2, m_data[0], m_data[1], $time);
      end
      checks++;
      if (xfer_cnt !== CNT_W'(m_cnt)) begin
         errors++; $display("FAIL xfer_cnt: got %0d want %0d at %0t", xfer_cnt, m_cnt % 16, $time);
      end
      if (m_pres >= 0) begin
         mux = bus_sel ? bus_2 : bus_1;
         checks++;
         if (mux !== m_data[m_pres]) begin
            errors++; $display("FAIL mux_word: got %h want %h at %0t", mux, m_data[m_pres], $time);
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      a_valid = 0; b_valid = 0; out_ready = 0;
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (out_valid !== 0 || bus_sel !== 0 || a_ready !== 1 || b_ready !== 1 ||
          bus_1 !== 0 || bus_2 !== 0 || xfer_cnt !== 0) begin
         errors++; $display("FAIL reset_vals: got v=%b s=%b ar=%b br=%b b1=%h b2=%h cnt=%0d want 0 0 1 1 0 0 0",
                            out_valid, bus_sel, a_ready, b_ready, bus_1, bus_2, xfer_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      step(0, 0, 0, 0, 1);
   endtask

   task automatic test_single_a();
      logic [3:0] mux;
      do_reset();
      step(1, 4'h5, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      mux = bus_sel ? bus_2 : bus_1;
      checks++;
      if (out_valid !== 1 || bus_sel !== 0 || mux !== 4'h5) begin
         errors++; $display("FAIL single_a: got v=%b s=%b word=%h want 1 0 5", out_valid, bus_sel, mux);
      end
      step(0, 0, 0, 0, 1);
      checks++;
      if (xfer_cnt !== 1 || out_valid !== 0) begin
         errors++; $display("FAIL single_a_cnt: got cnt=%0d v=%b want 1 0", xfer_cnt, out_valid);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      step(0, 0, 1, 4'hA, 0);
      step(0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         step(i == 0, 4'h3, 0, 0, 0);
         checks++;
         if (bus_sel !== 1 || bus_2 !== 4'hA || out_valid !== 1) begin
            errors++; $display("FAIL hold_b: got s=%b b2=%h v=%b want 1 a 1", bus_sel, bus_2, out_valid);
         end
      end
      checks++;
      if (bus_1 !== 4'h3 || a_ready !== 0) begin
         errors++; $display("FAIL hold_a_cap: got b1=%h ar=%b want 3 0", bus_1, a_ready);
      end
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
   endtask

   task automatic test_stream();
      do_reset();
      for (int i = 0; i < 40; i++)
         step(1, 4'($urandom), 1, 4'($urandom), 1);
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++)
         step(1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0));
   endtask

   task automatic test_wrap();
      int n;
      do_reset();
      n = 0;
      while (m_cnt < 17 && n < 200) begin
         step(1, 4'($urandom), 1'($urandom), 4'($urandom), 1);
         n++;
      end
      checks++;
      if (m_cnt != 17 || xfer_cnt !== 4'd1) begin
         errors++; $display("FAIL wrap: got cnt=%0d after %0d model xfers want 1 after 17", xfer_cnt, m_cnt);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      step(1, 4'h6, 1, 4'h9, 0);
      step(0, 0, 0, 0, 0);
      checks++;
      if (out_valid !== 1 || a_ready !== 0 || b_ready !== 0) begin
         errors++; $display("FAIL pre_reset: got v=%b ar=%b br=%b want 1 0 0", out_valid, a_ready, b_ready);
      end
      out_ready = 1;
      #3 rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (out_valid !== 0 || bus_sel !== 0 || a_ready !== 1 || b_ready !== 1 ||
          bus_1 !== 0 || bus_2 !== 0 || xfer_cnt !== 0) begin
         errors++; $display("FAIL mid_reset: got v=%b s=%b ar=%b br=%b b1=%h b2=%h cnt=%0d want 0 0 1 1 0 0 0",
                            out_valid, bus_sel, a_ready, b_ready, bus_1, bus_2, xfer_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single_a();
      test_backpressure();
      test_stream();
      test_random();
      test_wrap();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
